// File: rtl/barrel_shift_pipe.sv
// ---------------------------------------------------------------------------
// barrel_shift_pipe
//   Pipelined rotate / logical shift / arithmetic shift, left or right, on a
//   BIT-wide word. There is one register stage per mux level, so there are
//   S = $clog2(BIT) stages. Stage k shifts by 2^(S-1-k) when shift-amount
//   bit S-1-k is set. A word appears on o_valid S cycles after it is accepted.
//   The pipeline has a single global enable, so a stalled consumer holds
//   every stage.
//
// Parameters
//   BIT    data width, a power of two, >= 2
//   TAG_W  sideband tag width, >= 1
//
// Ports
//   i_clk, i_rst        clock and synchronous active-high reset
//   i_valid / o_ready   input handshake
//   i_data, i_tag       input word and tag; the tag passes through unchanged
//   i_sel_left          1 = left, 0 = right
//   i_mode              00 rotate, 01 logical, 10 arithmetic, 11 bypass
//   i_shifter           shift amount, 0..BIT-1
//   o_valid / i_ready   output handshake
//   o_data, o_tag       shifted result and its tag
// ---------------------------------------------------------------------------
module barrel_shift_pipe #(
  parameter int BIT   = 8,
  parameter int TAG_W = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [BIT-1:0]           i_data,
  input  logic [TAG_W-1:0]         i_tag,
  input  logic                     i_sel_left,
  input  logic [1:0]               i_mode,
  input  logic [$clog2(BIT)-1:0]   i_shifter,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [BIT-1:0]           o_data,
  output logic [TAG_W-1:0]         o_tag
);

  localparam int S = $clog2(BIT);

  typedef enum logic [1:0] {
    MODE_ROT = 2'b00,
    MODE_LSH = 2'b01,
    MODE_ASH = 2'b10,
    MODE_BYP = 2'b11
  } mode_e;

  // Everything a word needs on its way through the stages. The sign bit is
  // captured at accept, because earlier right shifts move the data MSB.
  typedef struct packed {
    logic [BIT-1:0]   data;
    logic [TAG_W-1:0] tag;
    logic             left;
    mode_e            mode;
    logic             sign;
    logic [S-1:0]     shamt;
  } word_t;

  word_t          in_word;
  word_t          stage_in [S];
  word_t          stage_d  [S];
  word_t          stage_q  [S];
  logic [S-1:0]   valid_q;
  logic           en;

  // One mux level: shift by a fixed amount 'amt' when do_shift is set.
  // Arithmetic left is the same as logical left. Arithmetic right with the
  // sign set fills with ones: invert, shift in zeros, invert back.
  function automatic word_t shift_level(input word_t w, input int amt,
                                        input logic do_shift);
    word_t r;
    r = w;
    if (do_shift) begin
      case (w.mode)
        MODE_ROT: r.data = w.left ? ((w.data << amt) | (w.data >> (BIT - amt)))
                                  : ((w.data >> amt) | (w.data << (BIT - amt)));
        MODE_LSH: r.data = w.left ? (w.data << amt) : (w.data >> amt);
        MODE_ASH: r.data = w.left ? (w.data << amt)
                                  : (w.sign ? ~(~w.data >> amt) : (w.data >> amt));
        default:  r.data = w.data;
      endcase
    end
    return r;
  endfunction

  assign en      = ~o_valid | i_ready;
  assign o_ready = en;
  assign o_valid = valid_q[S-1];
  assign o_data  = stage_q[S-1].data;
  assign o_tag   = stage_q[S-1].tag;

  always_comb begin
    // NOTE: the combinational blocks assign every output first, so each path
    // drives a value and no latch is inferred. They use blocking '=' because
    // later lines read values computed earlier in the same pass.
    in_word = '{data:  i_data,
                tag:   i_tag,
                left:  i_sel_left,
                mode:  mode_e'(i_mode),
                sign:  i_data[BIT-1],
                shamt: i_shifter};
    stage_in[0] = in_word;
    for (int k = 1; k < S; k++) stage_in[k] = stage_q[k-1];
    for (int k = 0; k < S; k++)
      stage_d[k] = shift_level(stage_in[k], 1 << (S - 1 - k),
                               stage_in[k].shamt[S-1-k]);
  end

  // Reset takes priority over en. While en is high, every stage advances.
  // Bubbles move along with their (don't-care) data and are never collapsed.
  always_ff @(posedge i_clk) begin
    // NOTE: the data and tag registers are reset along with the valid bits.
    // A reset must leave o_data and o_tag reading zero, not stale contents.
    if (i_rst) begin
      valid_q <= '0;
      for (int k = 0; k < S; k++) stage_q[k] <= '0;
    end else if (en) begin
      // NOTE: non-blocking '<=' here. Every stage samples the value its
      // predecessor held before this edge, which makes a real shift register.
      valid_q[0] <= i_valid;
      for (int k = 1; k < S; k++) valid_q[k] <= valid_q[k-1];
      stage_q <= stage_d;
    end
  end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// ---------------------------------------------------------------------------
// tb_barrel_shift_pipe
//   Directed checks on an 8-bit / 4-bit-tag instance: reset state, each mode
//   and direction, bypass and zero shift, latency, streaming under a stall,
//   and reset with words in flight. A 32-bit / 1-bit-tag instance then takes
//   a stream of random words under random backpressure. Its results are
//   compared against a bit-level reference model.
// ---------------------------------------------------------------------------
module tb_barrel_shift_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic rst;

  // 8-bit instance
  logic       a_valid, a_ready, a_left, a_ovalid, a_iready;
  logic [7:0] a_data, a_odata;
  logic [3:0] a_tag, a_otag;
  logic [1:0] a_mode;
  logic [2:0] a_sh;

  // 32-bit instance
  logic        b_valid, b_ready, b_left, b_ovalid, b_iready;
  logic [31:0] b_data, b_odata;
  logic        b_tag, b_otag;
  logic [1:0]  b_mode;
  logic [4:0]  b_sh;

  barrel_shift_pipe #(.BIT(8), .TAG_W(4)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .o_ready(a_ready),
    .i_data(a_data), .i_tag(a_tag), .i_sel_left(a_left), .i_mode(a_mode),
    .i_shifter(a_sh), .o_valid(a_ovalid), .i_ready(a_iready),
    .o_data(a_odata), .o_tag(a_otag));

  barrel_shift_pipe #(.BIT(32), .TAG_W(1)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_ready(b_ready),
    .i_data(b_data), .i_tag(b_tag), .i_sel_left(b_left), .i_mode(b_mode),
    .i_shifter(b_sh), .o_valid(b_ovalid), .i_ready(b_iready),
    .o_data(b_odata), .o_tag(b_otag));

  task automatic check(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Bit-level reference: for each result bit, locate its source bit.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int w,
                                            input bit left, input logic [1:0] mode,
                                            input int sh);
    logic [31:0] r;
    int src;
    r = '0;
    for (int i = 0; i < w; i++) begin
      if (mode == 2'b11 || sh == 0) r[i] = d[i];
      else if (left) begin
        src = i - sh;
        if (src >= 0)           r[i] = d[src];
        else if (mode == 2'b00) r[i] = d[src + w];
        else                    r[i] = 1'b0;
      end else begin
        src = i + sh;
        if (src < w)            r[i] = d[src];
        else if (mode == 2'b00) r[i] = d[src - w];
        else if (mode == 2'b10) r[i] = d[w - 1];
        else                    r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  // Send one word into the empty 8-bit pipe and check its latency, result
  // and tag. Latency counts rising edges, the accepting edge included.
  task automatic send8(input string name, input logic [7:0] data,
                       input logic [3:0] tag, input logic left,
                       input logic [1:0] mode, input logic [2:0] sh,
                       input logic [7:0] exp);
    int lat;
    @(negedge clk);
    a_iready = 1'b1;
    a_valid  = 1'b1;
    a_data   = data;
    a_tag    = tag;
    a_left   = left;
    a_mode   = mode;
    a_sh     = sh;
    #1 check({name, "_ready"}, a_ready, 1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    a_valid = 1'b0;
    while (!a_ovalid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({name, "_lat"}, lat, 3);
    check({name, "_data"}, a_odata, exp);
    check({name, "_tag"}, a_otag, tag);
  endtask

  logic [7:0]  exp8 [16];
  logic [7:0]  hold_d;
  logic [3:0]  hold_t;
  logic [31:0] q_d [$];
  logic        q_t [$];
  int sent, rx, ghost, bsent, brx;

  initial begin
    rst = 1'b1;
    a_valid = 0; a_data = 0; a_tag = 0; a_left = 0; a_mode = 0; a_sh = 0; a_iready = 1;
    b_valid = 0; b_data = 0; b_tag = 0; b_left = 0; b_mode = 0; b_sh = 0; b_iready = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", a_ovalid, 0);
    check("rst_data", a_odata, 0);
    check("rst_tag", a_otag, 0);
    check("rst_ready", a_ready, 1);
    check("rst_valid32", b_ovalid, 0);

    // Directed mode / direction vectors (BIT = 8)
    send8("rol1",   8'h81, 4'h1, 1'b1, 2'b00, 3'd1, 8'h03);
    send8("ror1",   8'h81, 4'h2, 1'b0, 2'b00, 3'd1, 8'hC0);
    send8("lsr3",   8'h81, 4'h3, 1'b0, 2'b01, 3'd3, 8'h10);
    send8("asr3n",  8'h81, 4'h4, 1'b0, 2'b10, 3'd3, 8'hF0);
    send8("asr3p",  8'h41, 4'h5, 1'b0, 2'b10, 3'd3, 8'h08);
    send8("lsl7",   8'h81, 4'h6, 1'b1, 2'b01, 3'd7, 8'h80);
    send8("asl1",   8'h81, 4'h7, 1'b1, 2'b10, 3'd1, 8'h02);
    send8("bypass", 8'h5A, 4'h8, 1'b1, 2'b11, 3'd5, 8'h5A);
    send8("zero_rot", 8'hA5, 4'h9, 1'b1, 2'b00, 3'd0, 8'hA5);
    send8("zero_lsh", 8'hA5, 4'hA, 1'b0, 2'b01, 3'd0, 8'hA5);
    send8("zero_ash", 8'hA5, 4'hB, 1'b0, 2'b10, 3'd0, 8'hA5);
    send8("zero_byp", 8'hA5, 4'hC, 1'b1, 2'b11, 3'd0, 8'hA5);

    // Streaming 16 words with a 4-cycle consumer stall (cycles 6..9)
    for (int t = 0; t < 16; t++)
      exp8[t] = 8'(ref_shift(32'(8'(t * 37 + 5)), 8, t[0], 2'(t % 4), t % 8));
    sent = 0;
    rx = 0;
    hold_d = '0;
    hold_t = '0;
    for (int cyc = 0; cyc < 60 && rx < 16; cyc++) begin
      @(negedge clk);
      a_iready = !(cyc >= 6 && cyc < 10);
      a_valid  = (sent < 16);
      a_data   = 8'(sent * 37 + 5);
      a_tag    = 4'(sent);
      a_left   = sent[0];
      a_mode   = 2'(sent % 4);
      a_sh     = 3'(sent % 8);
      #1;
      if (cyc >= 6 && cyc < 10) begin
        check("stall_ready", a_ready, 0);
        if (cyc > 6) begin
          check("stall_data", a_odata, hold_d);
          check("stall_tag", a_otag, hold_t);
        end
        hold_d = a_odata;
        hold_t = a_otag;
      end else if (rx > 0) begin
        check("stream_rate", a_ovalid, 1);
      end
      if (a_ovalid && a_iready) begin
        if (rx == 0) check("stream_first", cyc, 3);
        check("stream_data", a_odata, exp8[rx]);
        check("stream_tag", a_otag, rx);
        rx++;
      end
      if (a_valid && a_ready) sent++;
    end
    check("stream_rx", rx, 16);
    check("stream_sent", sent, 16);
    @(negedge clk);
    a_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("stream_drain", a_ovalid, 0);

    // Reset with three words in flight
    a_iready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_valid = 1'b1;
      a_data  = 8'(8'h10 + i);
      a_tag   = 4'(4'hA + i);
      a_left  = 1'b1;
      a_mode  = 2'b00;
      a_sh    = 3'd1;
    end
    @(negedge clk);
    a_valid  = 1'b0;
    a_iready = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_valid", a_ovalid, 0);
    check("midrst_data", a_odata, 0);
    check("midrst_tag", a_otag, 0);
    check("midrst_ready", a_ready, 1);
    a_iready = 1'b1;
    ghost = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_ovalid) ghost++;
    end
    check("midrst_ghost", ghost, 0);
    send8("post_rst", 8'h81, 4'h7, 1'b1, 2'b00, 3'd1, 8'h03);

    // BIT = 32: 1000 random words under random backpressure
    bsent = 0;
    brx = 0;
    for (int cyc = 0; cyc < 5000 && brx < 1000; cyc++) begin
      @(negedge clk);
      b_iready = (cyc < 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
      b_valid  = (bsent < 1000) && (cyc == 0 || $urandom_range(0, 9) != 0);
      b_data   = $urandom;
      b_left   = 1'($urandom_range(0, 1));
      b_mode   = 2'($urandom_range(0, 3));
      b_sh     = 5'($urandom_range(0, 31));
      b_tag    = 1'(bsent);
      #1;
      if (b_ovalid && b_iready) begin
        if (q_d.size() == 0) begin
          check("rnd_extra", b_ovalid, 0);
        end else begin
          if (brx == 0) check("rnd_first", cyc, 5);
          check("rnd_data", b_odata, q_d.pop_front());
          check("rnd_tag", b_otag, q_t.pop_front());
          brx++;
        end
      end
      if (b_valid && b_ready) begin
        q_d.push_back(ref_shift(b_data, 32, b_left, b_mode, int'(b_sh)));
        q_t.push_back(b_tag);
        bsent++;
      end
    end
    check("rnd_rx", brx, 1000);
    check("rnd_left", q_d.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
